// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer game core.
// Holds the phase encoding visible on the phase output and the default
// timing constants used by reaction_core.
package reaction_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_COUNT  = 2'd1,
    PH_RESULT = 2'd2,
    PH_SHOW   = 2'd3
  } phase_t;

  localparam int TICK_BASE_DEF = 1000000;
  localparam int BUCKET_DEF    = 30;

endpackage

// File: rtl/reaction_core_btn_edge.sv
// Rising-edge detector for one already-synchronised button.
// Ports: clk, rst (async active-low), btn (level), press (one-cycle pulse
// on the first cycle btn is seen high). History clears to 0 in reset so a
// button held through reset release is reported as a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_prev <= 1'b0;
    else      btn_prev <= btn;
  end

  assign press = btn & ~btn_prev;

endmodule

// File: rtl/reaction_core.sv
// Reaction-timer game core: pick a difficulty, reveal a random target,
// count up at a mode-dependent rate, stop as close to the target as you can.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        async active-low reset
//   btn_up/dn  mode up/down buttons (synchronised levels)
//   btn_sel    select/stop button (synchronised level)
//   rand_num   free-running random value, sampled as the round target
//   phase      0 IDLE, 1 COUNT, 2 RESULT, 3 SHOW
//   mode       selected difficulty
//   number     displayed value (target, running count or score)
//   led        score bar, more lit LEDs for a closer stop
//   round_cnt  completed rounds, wraps at 256
// Optional (macro REACT_BEST_EN):
//   best_score lowest score seen since reset, all ones after reset
//   new_best   high in RESULT when this round improved best_score
//
// state  | meaning
// IDLE   | mode selectable, sel latches a target
// SHOW   | target displayed, sel starts counting
// COUNT  | number increments once per period, sel or overflow stops
// RESULT | score and bar displayed, sel ends the round
module reaction_core
  import reaction_pkg::*;
#(
  parameter int NUM_W     = 14,
  parameter int LED_N     = 16,
  parameter int NUM_MODES = 3,
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int BUCKET    = BUCKET_DEF,
  parameter int MODE_RST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             btn_sel,
  input  logic [NUM_W-1:0] rand_num,
  output logic [1:0]       phase,
  output logic [1:0]       mode,
  output logic [NUM_W-1:0] number,
  output logic [LED_N-1:0] led,
  output logic [7:0]       round_cnt
`ifdef REACT_BEST_EN
  ,
  output logic [NUM_W-1:0] best_score,
  output logic             new_best
`endif
);

  localparam int TICK_W = $clog2(TICK_BASE + 1);
  localparam logic [NUM_W-1:0] NUM_MAX = '1;

  logic up_press, dn_press, sel_press;

  btn_edge u_up  (.clk(clk), .rst(rst), .btn(btn_up),  .press(up_press));
  btn_edge u_dn  (.clk(clk), .rst(rst), .btn(btn_dn),  .press(dn_press));
  btn_edge u_sel (.clk(clk), .rst(rst), .btn(btn_sel), .press(sel_press));

  phase_t             phase_q, phase_d;
  logic [1:0]         mode_q, mode_d;
  logic [NUM_W-1:0]   number_q, number_d;
  logic [NUM_W-1:0]   target_q, target_d;
  logic [LED_N-1:0]   led_q, led_d;
  logic [7:0]         round_q, round_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [TICK_W-1:0]  period;
  logic [NUM_W-1:0]   score;
  logic [31:0]        off;
  logic [LED_N-1:0]   bar;
`ifdef REACT_BEST_EN
  logic [NUM_W-1:0]   best_q, best_d;
  logic               nb_q, nb_d;
`endif

  // mode cannot change outside IDLE, so the period is frozen for the round
  assign period = TICK_W'(TICK_BASE >> mode_q);
  assign score  = (number_q >= target_q) ? number_q - target_q : target_q - number_q;
  assign off    = 32'(score) / 32'(BUCKET);
  // ~((1<<off)-1) is all ones shifted left by off
  assign bar    = (32'(score) >= 32'(LED_N * BUCKET)) ? LED_N'(0) : ({LED_N{1'b1}} << off);

  always_comb begin
    phase_d  = phase_q;
    mode_d   = mode_q;
    number_d = number_q;
    target_d = target_q;
    led_d    = led_q;
    round_d  = round_q;
    tick_d   = tick_q;
`ifdef REACT_BEST_EN
    best_d   = best_q;
    nb_d     = nb_q;
`endif
    case (phase_q)
      PH_IDLE: begin
        if (up_press && !dn_press && int'(mode_q) < NUM_MODES - 1)
          mode_d = mode_q + 2'd1;
        else if (dn_press && !up_press && mode_q != 2'd0)
          mode_d = mode_q - 2'd1;
        if (sel_press) begin
          target_d = (rand_num == '0) ? NUM_W'(1) : rand_num;
          number_d = (rand_num == '0) ? NUM_W'(1) : rand_num;
          phase_d  = PH_SHOW;
        end
      end
      PH_SHOW: begin
        if (sel_press) begin
          number_d = '0;
          tick_d   = '0;
          phase_d  = PH_COUNT;
        end
      end
      PH_COUNT: begin
        // stop wins over a coincident tick wrap: score uses the current number
        if (sel_press || number_q == NUM_MAX) begin
          phase_d  = PH_RESULT;
          number_d = score;
          led_d    = bar;
`ifdef REACT_BEST_EN
          if (score < best_q) begin
            best_d = score;
            nb_d   = 1'b1;
          end else begin
            nb_d   = 1'b0;
          end
`endif
        end else if (tick_q == period - TICK_W'(1)) begin
          tick_d   = '0;
          number_d = number_q + NUM_W'(1);
        end else begin
          tick_d   = tick_q + TICK_W'(1);
        end
      end
      PH_RESULT: begin
        if (sel_press) begin
          phase_d  = PH_IDLE;
          led_d    = '0;
          number_d = '0;
          round_d  = round_q + 8'd1;
`ifdef REACT_BEST_EN
          nb_d     = 1'b0;
`endif
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_IDLE;
      mode_q   <= 2'(MODE_RST);
      number_q <= '0;
      target_q <= '0;
      led_q    <= '0;
      round_q  <= '0;
      tick_q   <= '0;
`ifdef REACT_BEST_EN
      best_q   <= '1;
      nb_q     <= 1'b0;
`endif
    end else begin
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      number_q <= number_d;
      target_q <= target_d;
      led_q    <= led_d;
      round_q  <= round_d;
      tick_q   <= tick_d;
`ifdef REACT_BEST_EN
      best_q   <= best_d;
      nb_q     <= nb_d;
`endif
    end
  end

  assign phase     = phase_q;
  assign mode      = mode_q;
  assign number    = number_q;
  assign led       = led_q;
  assign round_cnt = round_q;
`ifdef REACT_BEST_EN
  assign best_score = best_q;
  assign new_best   = nb_q;
`endif

endmodule
